// File: rtl/hls_phi_add_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hls_phi_add_unit_pkg
// Purpose  : Shared constants for the phi/add loop-carried-value datapath.
//            BB_ID_W      - width of every basic-block ID
//            ENTRY_BB     - ID of the entry block (reset value of last_block)
//            DEFAULT_*    - default data width and phi pair count
// Revision : 1.0 - initial release
// ============================================================================
package hls_phi_add_unit_pkg;

    localparam int BB_ID_W         = 32;
    localparam logic [BB_ID_W-1:0] ENTRY_BB = '0;
    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_NB_PAIR = 2;

endpackage
`default_nettype wire

// File: rtl/hls_phi_add_unit_add.sv
`default_nettype none
// ============================================================================
// Module   : add
// Purpose  : Modular unsigned adder, out = (in0 + in1) mod 2^WIDTH.
// Ports    : in0, in1 - operands (WIDTH)
//            out      - sum with carry-out discarded (WIDTH)
// Revision : 1.0 - initial release
// ============================================================================
module add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);

    // Result truncated to WIDTH: signed and unsigned wrap coincide.
    assign out = in0 + in1;

endmodule
`default_nettype wire

// File: rtl/hls_phi_add_unit_br_dummy.sv
`default_nettype none
// ============================================================================
// Module   : br_dummy
// Purpose  : Branch-unit marker; kept so generated netlists keep the same
//            hierarchy. No ports, no behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module br_dummy;
endmodule
`default_nettype wire

// File: rtl/hls_phi_add_unit_phi.sv
`default_nettype none
// ============================================================================
// Module   : phi
// Purpose  : Phi multiplexer keyed on the last executed basic block.
//            Selects the value of the lowest-index pair whose block ID equals
//            last_block; drives zero when no pair matches.
// Ports    : in         - packed values, pair i at [i*WIDTH +: WIDTH]
//            s          - packed block IDs, pair i at [i*BB_ID_W +: BB_ID_W]
//            last_block - ID of the most recently completed block
//            out        - selected value (WIDTH)
// Revision : 1.0 - initial release
// ============================================================================
module phi
    import hls_phi_add_unit_pkg::*;
#(
    parameter int NB_PAIR = DEFAULT_NB_PAIR,
    parameter int WIDTH   = DEFAULT_WIDTH
) (
    input  logic [NB_PAIR*WIDTH-1:0]   in,
    input  logic [NB_PAIR*BB_ID_W-1:0] s,
    input  logic [BB_ID_W-1:0]         last_block,
    output logic [WIDTH-1:0]           out
);

    // Scan from the highest pair down so that the lowest matching index is
    // the last to write and therefore wins when IDs are duplicated.
    always_comb begin
        out = '0;
        for (int i = NB_PAIR - 1; i >= 0; i--) begin
            if (s[i*BB_ID_W +: BB_ID_W] == last_block) begin
                out = in[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hls_phi_add_unit.sv
`default_nettype none
// ============================================================================
// Module   : hls_phi_add_unit
// Purpose  : Loop-carried-value datapath: i = phi(init, i_next);
//            i_next = i + step. Tracks the last executed basic block, selects
//            the phi input keyed on it, adds step and registers the sum.
// Ports    : clk, rst   - clock and asynchronous active-high reset
//            bb_en      - load bb_id into last_block
//            bb_id      - ID of the block just completed
//            phi_in     - packed phi values (NB_PAIR x WIDTH)
//            phi_s      - packed phi block IDs (NB_PAIR x 32)
//            step       - increment operand
//            res_en     - load sum into result
//            last_block - registered last-block ID
//            phi_out    - combinational phi selection
//            sum        - combinational phi_out + step
//            result     - registered sum
// Revision : 1.0 - initial release
// ============================================================================
module hls_phi_add_unit
    import hls_phi_add_unit_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NB_PAIR = DEFAULT_NB_PAIR
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       bb_en,
    input  logic [BB_ID_W-1:0]         bb_id,
    input  logic [NB_PAIR*WIDTH-1:0]   phi_in,
    input  logic [NB_PAIR*BB_ID_W-1:0] phi_s,
    input  logic [WIDTH-1:0]           step,
    input  logic                       res_en,
    output logic [BB_ID_W-1:0]         last_block,
    output logic [WIDTH-1:0]           phi_out,
    output logic [WIDTH-1:0]           sum,
    output logic [WIDTH-1:0]           result
);

    logic [BB_ID_W-1:0] r_last_block;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_phi_out;
    logic [WIDTH-1:0]   w_sum;

    // Both registers sample on the same edge, so with bb_en and res_en high
    // together result captures the sum selected by the pre-edge last_block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_block <= ENTRY_BB;
        end else if (bb_en) begin
            r_last_block <= bb_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
        end else if (res_en) begin
            r_result <= w_sum;
        end
    end

    phi #(
        .NB_PAIR    (NB_PAIR),
        .WIDTH      (WIDTH)
    ) u_phi (
        .in         (phi_in),
        .s          (phi_s),
        .last_block (r_last_block),
        .out        (w_phi_out)
    );

    add #(
        .WIDTH (WIDTH)
    ) u_add (
        .in0   (w_phi_out),
        .in1   (step),
        .out   (w_sum)
    );

    br_dummy u_br_dummy ();

    assign last_block = r_last_block;
    assign phi_out    = w_phi_out;
    assign sum        = w_sum;
    assign result     = r_result;

endmodule
`default_nettype wire

// File: tb/tb_hls_phi_add_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hls_phi_add_unit
// Purpose  : Scoreboard bench for hls_phi_add_unit (WIDTH=8, NB_PAIR=2).
//            The driver queues hand-computed expectations and raises a sample
//            event; an independent monitor pops and compares on each event.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hls_phi_add_unit;

    localparam int WIDTH   = 8;
    localparam int NB_PAIR = 2;

    localparam int SEL_LB  = 0;
    localparam int SEL_PHI = 1;
    localparam int SEL_SUM = 2;
    localparam int SEL_RES = 3;

    logic                   clk;
    logic                   rst;
    logic                   bb_en;
    logic [31:0]            bb_id;
    logic [NB_PAIR*WIDTH-1:0] phi_in;
    logic [NB_PAIR*32-1:0]  phi_s;
    logic [WIDTH-1:0]       step;
    logic                   res_en;
    logic [31:0]            last_block;
    logic [WIDTH-1:0]       phi_out;
    logic [WIDTH-1:0]       sum;
    logic [WIDTH-1:0]       result;

    logic [WIDTH-1:0]       loop_val;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t queue_exp[$];
    event sample_ev;
    int   n_tests;
    int   n_fail;

    hls_phi_add_unit #(
        .WIDTH      (WIDTH),
        .NB_PAIR    (NB_PAIR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bb_en      (bb_en),
        .bb_id      (bb_id),
        .phi_in     (phi_in),
        .phi_s      (phi_s),
        .step       (step),
        .res_en     (res_en),
        .last_block (last_block),
        .phi_out    (phi_out),
        .sum        (sum),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pair 0 carries the initial value 0; pair 1 carries the loop value.
    always_comb phi_in = {loop_val, 8'd0};

    // ---------------- monitor ----------------
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (queue_exp.size() > 0) begin
                e = queue_exp.pop_front();
                case (e.sel)
                    SEL_LB:  act = last_block;
                    SEL_PHI: act = {24'd0, phi_out};
                    SEL_SUM: act = {24'd0, sum};
                    default: act = {24'd0, result};
                endcase
                n_tests++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic expect_val(input int sel, input logic [31:0] v, input string name);
        exp_t e;
        e.sel  = sel;
        e.exp  = v;
        e.name = name;
        queue_exp.push_back(e);
    endtask

    task automatic sample();
        #1;
        -> sample_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts rst away from any clock edge and releases it on a falling edge.
    task automatic pulse_reset_midcycle();
        tick();
        #2;
        rst = 1'b1;
        sample();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bb_en    = 1'b0;
        bb_id    = 32'd0;
        res_en   = 1'b0;
        step     = 8'd1;
        loop_val = 8'd0;
        phi_s    = {32'd1, 32'd0};

        repeat (2) tick();
        @(negedge clk);
        rst = 1'b0;

        // Move both registers away from zero so the reset is observable.
        tick();
        bb_en = 1'b1; bb_id = 32'd1; loop_val = 8'd5;
        tick();
        bb_en = 1'b0; res_en = 1'b1;
        tick();
        res_en = 1'b0;
        expect_val(SEL_RES, 32'd6, "pre_reset_result");
        sample();

        // Mid-cycle asynchronous reset.
        tick();
        #2;
        rst = 1'b1;
        expect_val(SEL_LB,  32'd0, "reset_last_block");
        expect_val(SEL_RES, 32'd0, "reset_result");
        expect_val(SEL_PHI, 32'd0, "reset_phi_out");
        expect_val(SEL_SUM, 32'd1, "reset_sum");
        sample();
        // Enables are ignored on an edge while rst is high.
        bb_en = 1'b1; res_en = 1'b1; bb_id = 32'd3;
        tick();
        expect_val(SEL_LB,  32'd0, "reset_hold_last_block");
        expect_val(SEL_RES, 32'd0, "reset_hold_result");
        sample();
        bb_en = 1'b0; res_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Entry then loop.
        tick();
        expect_val(SEL_SUM, 32'd1, "entry_sum");
        sample();
        bb_en = 1'b1; bb_id = 32'd1; loop_val = 8'd5;
        tick();
        bb_en = 1'b0;
        expect_val(SEL_LB,  32'd1, "loop_last_block");
        expect_val(SEL_PHI, 32'd5, "loop_phi_out");
        expect_val(SEL_SUM, 32'd6, "loop_sum");
        sample();
        res_en = 1'b1;
        tick();
        res_en = 1'b0;
        expect_val(SEL_RES, 32'd6, "loop_result");
        sample();

        // Counting loop from a clean reset.
        pulse_reset_midcycle();
        bb_en = 1'b1; bb_id = 32'd1; res_en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            loop_val = result;
            tick();
            expect_val(SEL_RES, k[31:0], "count_result");
            sample();
        end
        bb_en = 1'b0; res_en = 1'b0;

        // Wrap-around with last_block = 1.
        loop_val = 8'hFF;
        expect_val(SEL_PHI, 32'hFF, "wrap_phi_out");
        expect_val(SEL_SUM, 32'h00, "wrap_sum");
        sample();
        res_en = 1'b1;
        tick();
        res_en = 1'b0;
        expect_val(SEL_RES, 32'h00, "wrap_result");
        sample();

        // Unmatched block ID.
        bb_en = 1'b1; bb_id = 32'd7; loop_val = 8'd5;
        tick();
        bb_en = 1'b0;
        expect_val(SEL_LB,  32'd7, "unmatched_last_block");
        expect_val(SEL_PHI, 32'd0, "unmatched_phi_out");
        expect_val(SEL_SUM, 32'd1, "unmatched_sum");
        sample();
        // ID differing only in the top bit must not match pair 1.
        bb_en = 1'b1; bb_id = 32'h8000_0001;
        tick();
        bb_en = 1'b0;
        expect_val(SEL_PHI, 32'd0, "partial_id_phi_out");
        sample();

        // Duplicate IDs: lowest pair wins.
        pulse_reset_midcycle();
        phi_s    = {32'd0, 32'd0};
        loop_val = 8'h42;
        expect_val(SEL_PHI, 32'd0, "dup_phi_out");
        expect_val(SEL_SUM, 32'd1, "dup_sum");
        sample();
        phi_s = {32'd1, 32'd0};

        // Simultaneous enables from last_block = 0.
        tick();
        bb_en = 1'b1; res_en = 1'b1; bb_id = 32'd1; loop_val = 8'd9;
        tick();
        bb_en = 1'b0; res_en = 1'b0;
        expect_val(SEL_RES, 32'd1,  "simul_result");
        expect_val(SEL_PHI, 32'd9,  "simul_phi_out");
        expect_val(SEL_LB,  32'd1,  "simul_last_block");
        expect_val(SEL_SUM, 32'd10, "simul_sum");
        sample();

        // Every queued expectation should have been consumed.
        tick();
        n_tests++;
        if (queue_exp.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", queue_exp.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
